// File: rtl/tff_count_sequencer.sv
// Sequences a WIDTH-bit T flip-flop bank as a programmable up/down counter.
// Exports the per-bit toggle enables so an external TFF bank tracks q_o in lock-step.
module tff_count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] tog_o,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             done_q, wrap_q;
  logic             reload;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] s_val, e_val;

  assign s_val = dir_q ? lim_q : '0;
  assign e_val = dir_q ? '0 : lim_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tog     = '0;
    reload  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          mode_d  = mode_i;
          lim_d   = limit_i;
          q_d     = dir_i ? limit_i : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (pause_i) begin
          state_d = RUN;
        end else if (q_q == e_val) begin
          if (mode_q) begin
            tog    = q_q ^ s_val;
            reload = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (dir_q) begin
          tog = q_q ^ (q_q - ONE);
        end else begin
          tog = q_q ^ (q_q + ONE);
        end
        // Image update is purely the TFF rule, keeping it identical to the external bank.
        q_d = q_q ^ tog;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      done_q  <= (state_d == DONE);
      wrap_q  <= reload;
    end
  end

  assign tog_o  = tog;
  assign q_o    = q_q;
  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign wrap_o = wrap_q;

endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller that sequences a WIDTH-bit bank of T flip-flops as a programmable up/down counter.
- Each cycle it computes the per-bit toggle-enable vector and applies it to an internal state image. The same vector is exported so an external T flip-flop bank can be driven in lock-step.
- A start/done handshake frames each count run. Runs are one-shot or continuous (auto-reload), with pause and abort control.

Parameters:
- WIDTH, 8, number of T flip-flop bits sequenced (legal range 2..16).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run request; sampled only in IDLE
- dir  input  1  0 = count up, 1 = count down; latched at start
- mode  input  1  0 = one-shot, 1 = continuous; latched at start
- limit  input  WIDTH  terminal value; latched at start
- pause  input  1  hold count while high (RUN only)
- abort  input  1  terminate run immediately
- tog  output  WIDTH  toggle-enable vector (T inputs), combinational from state/count
- q  output  WIDTH  current count image (registered)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on one-shot completion (registered)
- wrap  output  1  one-cycle pulse on continuous reload (registered)

Behaviour:
- Reset: state=IDLE, q=0, busy=0, done=0, wrap=0, latched dir/mode/limit=0, tog=0. Reset wins over every other input, including mid-run.
- Start value S and terminal E:
  - up: S=0, E=limit.
  - down: S=limit, E=0.
- States are IDLE, RUN, DONE.
- IDLE:
  - tog=0.
  - start=1 at an edge: latch dir/mode/limit, load q=S, go to RUN.
  - start=0: q holds its last value.
- RUN, priority order abort > pause > terminal > step:
  - abort=1: next state IDLE, tog=0, q holds. No done or wrap pulse.
  - pause=1: tog=0, q holds, stay RUN.
  - q==E with mode=0: tog=0, next state DONE.
  - q==E with mode=1: tog = q ^ S, q reloads to S, wrap=1 for the following cycle, stay RUN.
  - otherwise, up: tog = q ^ (q+1). Down: tog = q ^ (q-1). Arithmetic is modulo 2^WIDTH.
  - Count update is always q_next = q ^ tog, so the internal image matches an external TFF bank.
- DONE:
  - done=1, busy=0, tog=0, q holds E.
  - Next edge goes to IDLE unconditionally.
  - start asserted while in DONE is ignored; it must be re-asserted in IDLE.
- busy=1 exactly while state==RUN.
- done and wrap are never high in the same cycle.
- start outside IDLE has no effect. Changes to dir/mode/limit during a run have no effect.
- limit=0:
  - up and down: S==E, so the first RUN cycle is terminal.
  - one-shot: RUN lasts 1 cycle, then DONE.
  - continuous: wrap pulses every cycle, and tog=0 because S^S=0.
- Latency:
  - up, one-shot, limit=L: start edge to done high is L+1 edges.
  - Continuous period is L+1 cycles per wrap.
- pause during the terminal cycle holds the state; the terminal action fires on the first non-paused cycle.
- abort in the same cycle as the terminal condition: abort wins, no done or wrap pulse.

Test Plan:
- Up, one-shot: rst, then start with dir=0, mode=0, limit=3 at edge0. Required:
  - q = 0,1,2,3 on edges 0..3.
  - tog = 01,11,01,00 (LSBs) on those cycles.
  - done=1 only after edge4; IDLE after edge5.
  - busy high edges 0..3.
- Down, continuous: limit=2, dir=1, mode=1. Required:
  - q = 2,1,0,2,1,0.
  - wrap=1 in the cycle after each 0 to 2 reload.
  - tog=10 on each reload cycle.
  - done never asserted.
- Pause: in an up run with limit=5, hold pause high for 3 cycles at q=2. Required:
  - q stays 2 and tog=0 for 3 cycles, then resumes 3,4,5.
  - done arrives 3 cycles later than unpaused.
- Abort versus terminal: assert abort exactly at q==limit. Required:
  - next state IDLE, q holds limit, done=0, wrap=0.
- Wrap-around at full scale: WIDTH=8, up, continuous, limit=255. Required:
  - q steps 254 to 255 with tog=0x01.
  - q steps 255 to 0 with tog=0xFF and wrap pulses.
- Reset mid-run and ignored start: assert rst at q=4. Required:
  - next cycle q=0, IDLE, all pulses 0.
  - separately, start held high through DONE does not restart until the cycle after entering IDLE.
